// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 timeout_err;

  modport master (
    output req, req_data, tx_done,
    input  ack, tx_start, tx_data, busy, grant_id, timeout_err
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, tx_start, tx_data, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   scan;
  logic                 pick_valid;
  logic [GW-1:0]        pick_id;
  logic [7:0]           pick_byte;
  int unsigned          base;
  int unsigned          off;
  int unsigned          sel;

  assign cnt_inc = cnt + CW'(1);

  // Rotate requests so last_grant+1 lands at bit 0, then take the lowest set bit.
  always_comb begin
    base       = 32'(last_grant) + 32'd1;
    req_dbl    = {bus.req, bus.req};
    req_rot    = NUM_REQ'(req_dbl >> base);
    scan       = req_rot;
    pick_valid = 1'b0;
    off        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && scan[0]) begin
        pick_valid = 1'b1;
        off        = i;
      end
      scan = scan >> 1;
    end
    sel       = (base + off) % NUM_REQ;
    pick_id   = GW'(sel);
    pick_byte = 8'(bus.req_data >> (8 * sel));
  end

  // Transfer sequencing with registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= GW'(NUM_REQ - 1);
      cnt             <= '0;
      bus.ack         <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.busy        <= 1'b0;
      bus.grant_id    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.ack         <= '0;
      bus.tx_start    <= 1'b0;
      bus.timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.tx_data  <= pick_byte;
            bus.grant_id <= pick_id;
            bus.tx_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          // Completion takes priority over the terminal count.
          if (bus.tx_done) begin
            bus.ack <= NUM_REQ'(1) << bus.grant_id;
            state   <= ACK;
          end else if (cnt_inc == TERM) begin
            bus.timeout_err <= 1'b1;
            bus.busy        <= 1'b0;
            last_grant      <= bus.grant_id;
            state           <= IDLE;
          end
        end
        ACK: begin
          bus.busy   <= 1'b0;
          last_grant <= bus.grant_id;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transfer-age reference model.
module tb_uart_tx_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 20;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a transfer is described by its age in cycles since tx_start.
  int          m_age;
  int          m_owner;
  int          m_last;
  bit          m_ackc;
  bit          m_toc;
  logic [7:0]  m_data;
  logic [7:0]  data_q[$];
  int          gnt_q[$];
  int          ack_q[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (((r >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : mdl
    int n_age;
    bit n_ack;
    bit n_to;
    int p;
    cyc++;
    if (!rst_n) begin
      m_age = -1; m_ackc = 0; m_toc = 0;
      m_owner = 0; m_data = 8'h00; m_last = N - 1;
    end
    chk("tx_start", bus.tx_start, m_age == 0);
    chk("busy", bus.busy, (m_age >= 0) || m_ackc);
    chk("ack", bus.ack, m_ackc ? (1 << m_owner) : 0);
    chk("timeout_err", bus.timeout_err, m_toc);
    chk("grant_id", bus.grant_id, m_owner);
    chk("tx_data", bus.tx_data, m_data);
    if (bus.tx_start === 1'b1) begin
      data_q.push_back(bus.tx_data);
      gnt_q.push_back(int'(bus.grant_id));
    end
    for (int i = 0; i < N; i++)
      if (((bus.ack >> i) & 1) != 0) ack_q.push_back(i);
    if (rst_n) begin
      n_age = -1; n_ack = 0; n_to = 0;
      if (m_age >= 0) begin
        if (m_age >= 1 && bus.tx_done === 1'b1) n_ack = 1;
        else if (m_age >= 1 && m_age + 1 == TO) begin
          n_to = 1;
          m_last = m_owner;
        end else n_age = m_age + 1;
      end else if (m_ackc) begin
        m_last = m_owner;
      end else begin
        p = rr_pick(bus.req, m_last);
        if (p >= 0) begin
          m_owner = p;
          m_data  = 8'(bus.req_data >> (8 * p));
          n_age   = 0;
        end
      end
      m_age = n_age; m_ackc = n_ack; m_toc = n_to;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start();
    int ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tx_start === 1'b1) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("wait_start", ok, 1);
  endtask

  // Finds the next tx_start, waits dly cycles, then pulses tx_done; returns in the ack cycle.
  task automatic serve(input int dly);
    wait_start();
    repeat (dly) step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.tx_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: run did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    logic [7:0] exp_d[4];
    int exp_g[4];
    total = 0; bad = 0; cyc = 0;
    m_age = -1; m_ackc = 0; m_toc = 0; m_owner = 0; m_data = 8'h00; m_last = N - 1;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;
    step(); step(); step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    rst_n = 1'b1;
    step();

    // Single requester 1; stray tx_done in IDLE ignored; req_data change after grant ignored.
    bus.tx_done = 1'b1; step(); bus.tx_done = 1'b0; step();
    bus.req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    bus.req = 4'b0010;
    step();
    chk("s1_tx_start", bus.tx_start, 1);
    chk("s1_tx_data", bus.tx_data, 8'hA5);
    chk("s1_grant", bus.grant_id, 1);
    bus.req_data = {8'h44, 8'h33, 8'h00, 8'h11};
    step();
    bus.tx_done = 1'b1; step(); bus.tx_done = 1'b0;
    chk("s1_ack", bus.ack, 4'b0010);
    chk("s1_data_held", bus.tx_data, 8'hA5);
    bus.req = '0;
    step();
    chk("s1_ack_clear", bus.ack, 0);
    chk("s1_busy_low", bus.busy, 0);

    // All four requesters: served 0,1,2,3 with their own bytes.
    do_reset();
    data_q.delete(); ack_q.delete();
    bus.req_data = {8'hFF, 8'h00, 8'hA5, 8'h55};
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(1 + i);
      bus.req = bus.req & ~(4'(1) << i);
    end
    step(); step();
    exp_d = '{8'h55, 8'hA5, 8'h00, 8'hFF};
    chk("s2_nstart", data_q.size(), 4);
    chk("s2_nack", ack_q.size(), 4);
    if (data_q.size() == 4 && ack_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("s2_data%0d", i), data_q[i], exp_d[i]);
        chk($sformatf("s2_ack%0d", i), ack_q[i], i);
      end

    // Requesters 0 and 2 held continuously alternate.
    do_reset();
    gnt_q.delete(); ack_q.delete();
    bus.req_data = {8'h04, 8'h03, 8'h02, 8'h01};
    bus.req = 4'b0101;
    for (int i = 0; i < 4; i++) serve(2);
    bus.req = '0;
    step(); step();
    exp_g = '{0, 2, 0, 2};
    chk("s3_ngrant", gnt_q.size(), 4);
    chk("s3_nack", ack_q.size(), 4);
    if (gnt_q.size() == 4 && ack_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("s3_grant%0d", i), gnt_q[i], exp_g[i]);
        chk($sformatf("s3_ack%0d", i), ack_q[i], exp_g[i]);
      end

    // Timeout on requester 0 with requester 1 arriving mid-transfer.
    ack_q.delete();
    bus.req = 4'b0001;
    wait_start();
    bus.req = 4'b0011;
    for (k = 1; k <= 40; k++) begin
      step();
      if (bus.timeout_err === 1'b1) break;
    end
    chk("s4_timeout_latency", k, TO);
    chk("s4_busy_low", bus.busy, 0);
    chk("s4_no_ack", ack_q.size(), 0);
    step();
    chk("s4_next_start", bus.tx_start, 1);
    chk("s4_next_grant", bus.grant_id, 1);
    bus.req = 4'b0010;
    serve(1);
    chk("s4_ack1", bus.ack, 4'b0010);
    bus.req = '0;
    step();

    // Asynchronous reset in the middle of WAIT.
    bus.req = 4'b0100;
    wait_start();
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rst_tx_start", bus.tx_start, 0);
    chk("s5_rst_busy", bus.busy, 0);
    chk("s5_rst_grant", bus.grant_id, 0);
    chk("s5_rst_tx_data", bus.tx_data, 8'h00);
    chk("s5_rst_ack", bus.ack, 0);
    chk("s5_rst_timeout", bus.timeout_err, 0);
    bus.req = 4'b1001;
    step();
    rst_n = 1'b1;
    step();
    chk("s5_first_start", bus.tx_start, 1);
    chk("s5_first_grant", bus.grant_id, 0);
    serve(1);
    bus.req = 4'b1000;
    serve(3);
    chk("s5_ack3", bus.ack, 4'b1000);
    bus.req = '0;
    step();

    // tx_done during START ignored; tx_done on the terminal WAIT cycle wins.
    bus.req = 4'b0001;
    wait_start();
    bus.tx_done = 1'b1; step(); bus.tx_done = 1'b0;
    repeat (TO - 2) step();
    bus.tx_done = 1'b1; step(); bus.tx_done = 1'b0;
    chk("s6_ack", bus.ack, 4'b0001);
    chk("s6_no_timeout", bus.timeout_err, 0);
    bus.req = '0;
    step(); step();
    chk("s6_no_late_timeout", bus.timeout_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 50000, max clk cycles from tx_start to tx_done before a transfer is abandoned.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester request level; bit k = requester k.
REQ-006 req_data  input  8*NUM_REQ  packed request bytes; requester k at bits [8k+7:8k].
REQ-007 ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte fully transmitted.
REQ-008 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte to transmit; stable from tx_start until transfer ends.
REQ-010 tx_done  input  1  one-cycle pulse from transmitter: stop bit finished.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester currently or last served.
REQ-013 timeout_err  output  1  one-cycle pulse: transfer abandoned at timeout.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT, ACK; Moore outputs.
REQ-015 IDLE: if any req bit set, select the first set bit searching from last_grant+1 upward, modulo NUM_REQ; latch its byte into tx_data, set grant_id, go to START; else stay.
REQ-016 START: tx_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
REQ-017 WAIT: increment counter each cycle; tx_done=1 -> ACK; counter reaching TIMEOUT-1 without tx_done -> timeout_err=1 for one cycle, last_grant=grant_id, go to IDLE, no ack.
REQ-018 ACK: ack[grant_id]=1 for this cycle only; last_grant=grant_id; go to IDLE.
REQ-019 Latency: req sampled in IDLE on edge n -> tx_start high in cycle n+1; tx_done sampled on edge m -> ack high in cycle m+1.
REQ-020 Requester SHALL hold req and req_data until ack; byte is latched at grant, so later changes to req_data or deassertion of req do not affect the current transfer.
REQ-021 tx_done outside WAIT SHALL be ignored.
REQ-022 tx_done and terminal count in the same cycle: tx_done wins; ACK, no timeout_err.
REQ-023 Round-robin: a requester held continuously SHALL not be granted twice while another requester is waiting.
REQ-024 Requests arriving during START/WAIT/ACK SHALL wait; re-arbitration only in IDLE.
REQ-025 Timeout counter width clog2(TIMEOUT+1); no wrap within a transfer.
REQ-026 At most one bit of ack, and never ack together with timeout_err, in any cycle.

Reset
REQ-027 reset low SHALL immediately force state IDLE, ack=0, tx_start=0, tx_data=8'h00, busy=0, grant_id=0, timeout_err=0, counter=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
REQ-028 Reset during any state SHALL abort the transfer without ack or timeout_err; operation resumes on the first clk edge after reset deasserts.

Verification
REQ-029 req=4'b0010, byte1=8'hA5 -> next cycle tx_start=1, tx_data=A5, grant_id=1; tx_done pulse -> ack=4'b0010 one cycle later, busy low after.
REQ-030 req=4'b1111, bytes 55,A5,00,FF -> tx_data sequence 55,A5,00,FF; each ack bit pulses exactly once, in order 0,1,2,3.
REQ-031 req0 and req2 held continuously -> grants alternate 0,2,0,2; requester 1 and 3 never acked.
REQ-032 req=4'b0001, tx_done never asserted -> timeout_err pulse TIMEOUT cycles after tx_start, no ack, busy low next cycle; with req1 pending, requester 1 served next.
REQ-033 reset asserted in WAIT -> all outputs at reset values asynchronously; after release with req=4'b1001, requester 0 granted first.
REQ-034 tx_done on terminal count cycle -> ack pulse, timeout_err stays 0.
